// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO that feeds a UART transmitter through a latch/busy
// handshake, and reports fill level and a sticky overflow flag for status.
module uart_tx_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_latch,
    input  logic              tx_busy,
    output logic              idle
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LATCH     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    logic [7:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              overflow_r;
    logic [7:0]        tx_data_r;
    logic              tx_latch_r;
    state_t            state_r;
    state_t            state_nx_s;
    logic              push_s;
    logic              drop_s;
    logic              pop_s;
    logic              load_s;
    logic              latch_nx_s;

    // Status flags decode straight from the occupancy register.
    assign full     = (count_r == DEPTH_C);
    assign empty    = (count_r == {(ADDR_W+1){1'b0}});
    assign level    = count_r;
    assign overflow = overflow_r;
    assign tx_data  = tx_data_r;
    assign tx_latch = tx_latch_r;
    assign idle     = empty && (state_r == S_IDLE) && !tx_busy;

    // Full is sampled before any same-cycle pop, so a push while full is always dropped.
    assign push_s = wr_en && !full;
    assign drop_s = wr_en && full;

    // Storage array; contents need no reset because pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; an unacknowledged latch falls back to idle and retries.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!empty && !tx_busy) begin
                    state_nx_s = S_LATCH;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_LATCH: begin
                state_nx_s = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nx_s = S_WAIT_DONE;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_WAIT_DONE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // FSM output decode: load, pop and the next value of the latch strobe.
    always_comb begin
        load_s     = 1'b0;
        pop_s      = 1'b0;
        latch_nx_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                load_s     = (state_nx_s == S_LATCH);
                latch_nx_s = (state_nx_s == S_LATCH);
            end
            S_WAIT_BUSY: begin
                pop_s = tx_busy;
            end
            default: begin
                load_s     = 1'b0;
                pop_s      = 1'b0;
                latch_nx_s = 1'b0;
            end
        endcase
    end

    // Registered transmitter interface; tx_data holds until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_r  <= 8'h00;
            tx_latch_r <= 1'b0;
        end else begin
            tx_latch_r <= latch_nx_s;
            if (load_s) begin
                tx_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Transmit-side byte queue that sits directly upstream of the UART transmitter. Bus write logic pushes bytes into it. The block drains them one at a time into the transmitter using its latch/busy handshake. This lets the CPU write bursts of up to DEPTH bytes without polling tx busy, and it reports fill level and sticky overflow for the status register.

Parameters:
DEPTH, 16, queue capacity in bytes; power of two, 2..256
ADDR_W, 4, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock (16 MHz)
rst  input  1  synchronous, active-high reset
wr_data  input  8  byte to enqueue
wr_en  input  1  one-cycle push strobe
ovf_clr  input  1  clears sticky overflow flag
full  output  1  queue holds DEPTH bytes
empty  output  1  queue holds 0 bytes
level  output  ADDR_W+1  bytes currently queued, 0..DEPTH
overflow  output  1  sticky: a push was dropped because the queue was full
tx_data  output  8  byte presented to transmitter data input
tx_latch  output  1  one-cycle load strobe to transmitter
tx_busy  input  1  transmitter busy; rises the cycle after an accepted latch
idle  output  1  queue empty, FSM in S_IDLE and tx_busy low

Behaviour:
- Storage: DEPTH x 8 register array; rd_ptr and wr_ptr are ADDR_W bits and wrap modulo DEPTH; count is ADDR_W+1 bits. full = (count == DEPTH); empty = (count == 0); level = count. All three are registered-state derived with no combinational path from wr_en.
- Push: when wr_en=1 and full=0 at the clock edge, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Dropped push: when wr_en=1 and full=1, the byte is dropped and overflow <= 1. Full is sampled before any same-cycle pop, so a push while full is dropped even if a pop occurs in that cycle.
- Overflow flag: ovf_clr=1 clears overflow. If a dropped push and ovf_clr occur in the same cycle, the set wins.
- Pop: occurs only on the S_WAIT_BUSY -> S_WAIT_DONE transition; rd_ptr increments.
- Count update: push only gives +1; pop only gives -1; push and pop in the same cycle leave count unchanged.
- tx_data: registered; loaded with mem[rd_ptr] on the S_IDLE -> S_LATCH transition; held stable through S_WAIT_DONE.
- FSM, 4 states, tx_latch registered (Moore):
  S_IDLE: if !empty && !tx_busy, go to S_LATCH and load tx_data.
  S_LATCH: tx_latch=1 for exactly this one cycle; go to S_WAIT_BUSY.
  S_WAIT_BUSY: if tx_busy=1, pop and go to S_WAIT_DONE. Otherwise the transmitter rejected the load: return to S_IDLE without popping, and the same byte is retried.
  S_WAIT_DONE: when tx_busy=0, go to S_IDLE.
- Latency: a push into an empty queue with the transmitter idle gives tx_latch high in the 2nd cycle after the wr_en cycle.
- Back-to-back bytes: the next tx_latch is 2 cycles after tx_busy falls.
- tx_latch is never asserted while tx_busy=1.
- Reset: mem contents are don't-care. rd_ptr, wr_ptr and count = 0; state = S_IDLE; tx_data = 0; tx_latch = 0; overflow = 0; full = 0; empty = 1; level = 0. idle = 1 once tx_busy=0.
- Reset mid-operation: all queued bytes are discarded. A byte already loaded into the transmitter finishes on the line; the FSM waits in S_IDLE for tx_busy=0 before issuing another latch.
- Wrap-around: pointers wrap without a gap; ordering is strictly FIFO across the wrap.

Test Plan:
- After reset, push 0x41 with tx_busy model idle -> tx_latch pulses 1 cycle, 2 cycles after wr_en, with tx_data=0x41. level goes 1->0 on busy rise; idle=1 after busy falls.
- Push 0x01..0x10 back-to-back (DEPTH=16, transmitter model busy for 100 cycles per byte) -> transmitter receives all 16 bytes in order. level peaks at 15 or 16, never exceeds 16. overflow stays 0.
- Hold tx_busy=1 externally, push 17 bytes -> full=1 after the 16th, 17th dropped, overflow=1. Pulse ovf_clr -> overflow=0. Release tx_busy -> bytes 1..16 emitted in order.
- Assert ovf_clr in the same cycle as a dropped push -> overflow=1 afterwards.
- Transmitter model ignores the first latch (busy stays 0) -> FSM returns to S_IDLE and re-latches the same byte. level is unchanged until busy is seen; no byte is lost or duplicated.
- Push 5 bytes, assert rst for 1 cycle while the 2nd byte is transmitting (tx_busy=1) -> level=0 and empty=1 after reset; no tx_latch until tx_busy falls. A new push afterwards is emitted normally. Repeat across pointer wrap: 40 pushes/pops keep FIFO order.
